// File: rtl/pkt_rx_pkg.sv
// Shared types and widths for the package-readout receiver.
package pkt_rx_pkg;
    localparam int DEF_DATA_W = 18;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GAP_W  = 8;
    localparam int WCNT_W     = 11;

    typedef enum logic [1:0] {
        PKT_LEN_216  = 2'b00,
        PKT_LEN_432  = 2'b01,
        PKT_LEN_864  = 2'b10,
        PKT_LEN_1728 = 2'b11
    } len_sel_e;

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, GAP} rx_state_e;

    function automatic logic [WCNT_W-1:0] len_words(input len_sel_e sel);
        return WCNT_W'(216) << sel;
    endfunction
endpackage

// File: rtl/pkt_rx_if.sv
// Pad-side input and tagged output stream of the receiver.
interface pkt_rx_if import pkt_rx_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              out_err;

    modport master (output in_data, in_valid,
                    input  out_data, out_valid, out_sop, out_eop, out_err);
    modport slave  (input  in_data, in_valid,
                    output out_data, out_valid, out_sop, out_eop, out_err);
endinterface

// File: rtl/pkt_rx_selftest_chk.sv
// Running-counter pattern checker; resyncs to received+1 after every word.
module pkt_rx_selftest_chk import pkt_rx_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] data,
    output logic              mismatch,
    output logic [CNT_W-1:0]  data_err_cnt
);
    logic [DATA_W-1:0] expected;

    assign mismatch = chk_en && (data != expected);

    // On a match data+1 equals expected+1, so one update covers both cases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected     <= '0;
            data_err_cnt <= '0;
        end else if (chk_en) begin
            expected <= data + 1'b1;
            if (mismatch && !(&data_err_cnt)) data_err_cnt <= data_err_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pkt_rx_capture.sv
// Frames VALID runs into SOP/EOP-tagged packets with length/gap checks.
// Build option PKT_RX_SELFTEST_EN adds the counter-pattern checker and data_err_cnt.
module pkt_rx_capture import pkt_rx_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GAP_W  = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic [1:0]       cfg_len_sel,
    input  logic [GAP_W-1:0] cfg_min_gap,
    pkt_rx_if.slave          rx,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [CNT_W-1:0] gap_err_cnt,
`ifdef PKT_RX_SELFTEST_EN
    output logic [CNT_W-1:0] data_err_cnt,
`endif
    output logic             busy
);
    rx_state_e         state;
    logic [DATA_W-1:0] s1_data, hold_data;
    logic              s1_valid, hold_sop, hold_derr;
    logic              seen_pkt, pkt_gap_err, sop_gap_err, derr;
    logic [WCNT_W-1:0] wcnt, pkt_len;
    logic [GAP_W-1:0]  gap_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef PKT_RX_SELFTEST_EN
    pkt_rx_selftest_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_chk (
        .clk          (clk),
        .rst          (rst),
        .chk_en       (cfg_en & s1_valid),
        .data         (s1_data),
        .mismatch     (derr),
        .data_err_cnt (data_err_cnt)
    );
`else
    assign derr = 1'b0;
`endif

    assign sop_gap_err = seen_pkt && (gap_cnt < cfg_min_gap);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= rx.in_data;
            s1_valid <= rx.in_valid;
        end
    end

    // The held word is emitted once the following sample is visible in s1,
    // which is what lets EOP be decided without a second look-ahead stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_data    <= '0;
            hold_sop     <= 1'b0;
            hold_derr    <= 1'b0;
            wcnt         <= '0;
            pkt_len      <= '0;
            gap_cnt      <= '0;
            seen_pkt     <= 1'b0;
            pkt_gap_err  <= 1'b0;
            pkt_cnt      <= '0;
            len_err_cnt  <= '0;
            gap_err_cnt  <= '0;
            rx.out_data  <= '0;
            rx.out_valid <= 1'b0;
            rx.out_sop   <= 1'b0;
            rx.out_eop   <= 1'b0;
            rx.out_err   <= 1'b0;
        end else begin
            rx.out_valid <= 1'b0;
            rx.out_sop   <= 1'b0;
            rx.out_eop   <= 1'b0;
            rx.out_err   <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (!cfg_en) begin
                        state    <= IDLE;
                        seen_pkt <= 1'b0;
                    end else if (s1_valid) begin
                        state       <= RECV;
                        hold_data   <= s1_data;
                        hold_sop    <= 1'b1;
                        hold_derr   <= derr;
                        wcnt        <= WCNT_W'(1);
                        pkt_len     <= len_words(len_sel_e'(cfg_len_sel));
                        pkt_gap_err <= sop_gap_err;
                        if (sop_gap_err) gap_err_cnt <= sat_inc(gap_err_cnt);
                        gap_cnt     <= '0;
                        seen_pkt    <= 1'b1;
                    end else if (state == GAP && !(&gap_cnt)) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RECV: begin
                    rx.out_valid <= 1'b1;
                    rx.out_data  <= hold_data;
                    rx.out_sop   <= hold_sop;
                    if (!cfg_en) begin
                        rx.out_eop  <= 1'b1;
                        rx.out_err  <= 1'b1;
                        len_err_cnt <= sat_inc(len_err_cnt);
                        state       <= IDLE;
                        seen_pkt    <= 1'b0;
                    end else if (wcnt == pkt_len) begin
                        rx.out_eop <= 1'b1;
                        rx.out_err <= pkt_gap_err | hold_derr;
                        if (s1_valid) begin
                            len_err_cnt <= sat_inc(len_err_cnt);
                            state       <= DRAIN;
                        end else begin
                            if (!pkt_gap_err) pkt_cnt <= sat_inc(pkt_cnt);
                            gap_cnt <= GAP_W'(1);
                            state   <= GAP;
                        end
                    end else if (!s1_valid) begin
                        rx.out_eop  <= 1'b1;
                        rx.out_err  <= 1'b1;
                        len_err_cnt <= sat_inc(len_err_cnt);
                        gap_cnt     <= GAP_W'(1);
                        state       <= GAP;
                    end else begin
                        rx.out_err <= hold_derr;
                        hold_data  <= s1_data;
                        hold_sop   <= 1'b0;
                        hold_derr  <= derr;
                        wcnt       <= wcnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!cfg_en) begin
                        state    <= IDLE;
                        seen_pkt <= 1'b0;
                    end else if (!s1_valid) begin
                        gap_cnt <= GAP_W'(1);
                        state   <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_rx_capture.sv
// Self-checking bench for pkt_rx_capture: directed table, corner sequences, random bursts.
module tb_pkt_rx_capture;
    import pkt_rx_pkg::*;
    localparam int DW = 18;
    localparam int CW = 3;
    localparam int GW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [1:0]    cfg_len_sel = 2'b00;
    logic [GW-1:0] cfg_min_gap = '0;
    logic [CW-1:0] pkt_cnt, len_err_cnt, gap_err_cnt;
    logic          busy;
`ifdef PKT_RX_SELFTEST_EN
    logic [CW-1:0] data_err_cnt;
`endif

    pkt_rx_if #(.DATA_W(DW)) bus ();

    pkt_rx_capture #(.DATA_W(DW), .CNT_W(CW), .GAP_W(GW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_en      (cfg_en),
        .cfg_len_sel (cfg_len_sel),
        .cfg_min_gap (cfg_min_gap),
        .rx          (bus),
        .pkt_cnt     (pkt_cnt),
        .len_err_cnt (len_err_cnt),
        .gap_err_cnt (gap_err_cnt),
`ifdef PKT_RX_SELFTEST_EN
        .data_err_cnt(data_err_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic          err;
    } word_t;

    typedef struct {
        int sel, mgap, n1, gap, n2;
        int e_pkt, e_len, e_gap, e_words;
    } vec_t;

    word_t         got_q[$], exp_q[$];
    logic [DW-1:0] bq[$];
    logic [DW-1:0] dc;
    int m_pkt, m_len, m_gap;
    int first_in_cyc, first_out_cyc, eop_cyc, fall_cyc;
    int n_chk = 0, n_fail = 0;

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            word_t w;
            w.d = bus.out_data; w.sop = bus.out_sop; w.eop = bus.out_eop; w.err = bus.out_err;
            got_q.push_back(w);
            if (bus.out_sop && first_out_cyc < 0) first_out_cyc = cyc;
            if (bus.out_eop) eop_cyc = cyc;
        end
    end

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word();
        logic [DW-1:0] d;
`ifdef PKT_RX_SELFTEST_EN
        d = dc;
`else
        d = DW'($urandom);
`endif
        dc = dc + 1'b1;
        if (first_in_cyc < 0) first_in_cyc = cyc + 1;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bq.push_back(d);
    endtask

    task automatic send_burst(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive_word();
        end
    endtask

    task automatic idle(input int g);
        for (int i = 0; i < g; i++) begin
            tick();
            if (bus.in_valid) fall_cyc = cyc + 1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        cfg_en = 1'b1;
        repeat (2) tick();
        got_q.delete(); exp_q.delete(); bq.delete();
        m_pkt = 0; m_len = 0; m_gap = 0; dc = '0;
        first_in_cyc = -1; first_out_cyc = -1; eop_cyc = -1; fall_cyc = -1;
        rst = 1'b0;
    endtask

    // Packet-level reference: a burst of n words preceded by gap idle cycles.
    task automatic model_burst(input int n, input int gap, input bit exempt, input int L);
        bit gerr;
        int ne;
        word_t w;
        gerr = !exempt && (gap < int'(cfg_min_gap));
        ne = (n < L) ? n : L;
        for (int i = 0; i < ne; i++) begin
            w.d = bq[i]; w.sop = (i == 0); w.eop = (i == ne - 1);
            w.err = (i == ne - 1) && ((n < L) || gerr);
            exp_q.push_back(w);
        end
        if (gerr) m_gap++;
        if (n != L) m_len++;
        else if (!gerr) m_pkt++;
        bq.delete();
    endtask

    task automatic check_words(input string name);
        int bad;
        bad = -1;
        check({name, " word count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] != exp_q[i]) begin
                bad = i;
                break;
            end
        end
        check({name, " first bad word index"}, bad, -1);
        if (bad >= 0) $display("  word %0d got %h wanted %h", bad, got_q[bad], exp_q[bad]);
    endtask

    task automatic check_model_counts(input string name);
        check({name, " pkt_cnt"}, int'(pkt_cnt), sat(m_pkt));
        check({name, " len_err_cnt"}, int'(len_err_cnt), sat(m_len));
        check({name, " gap_err_cnt"}, int'(gap_err_cnt), sat(m_gap));
    endtask

    vec_t vt[11];

    initial begin
        int L, nlast, held;
        vt[0]  = '{1, 8, 432, 15, 432, 2, 0, 0, 864};
        vt[1]  = '{0, 8, 200, 0, 0, 0, 1, 0, 200};
        vt[2]  = '{0, 8, 220, 0, 0, 0, 1, 0, 216};
        vt[3]  = '{0, 8, 216, 3, 216, 1, 0, 1, 432};
        vt[4]  = '{0, 8, 216, 8, 216, 2, 0, 0, 432};
        vt[5]  = '{0, 8, 216, 7, 216, 1, 0, 1, 432};
        vt[6]  = '{2, 0, 864, 0, 0, 1, 0, 0, 864};
        vt[7]  = '{3, 0, 1727, 0, 0, 0, 1, 0, 1727};
        vt[8]  = '{0, 0, 216, 1, 216, 2, 0, 0, 432};
        vt[9]  = '{0, 4, 300, 4, 216, 1, 1, 0, 432};
        vt[10] = '{0, 4, 217, 3, 215, 0, 2, 1, 431};
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        do_reset();
        check("reset flags", int'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err, busy}), 0);
        check("reset data", int'(bus.out_data), 0);
        check("reset counters", int'({pkt_cnt, len_err_cnt, gap_err_cnt}), 0);

        for (int v = 0; v < 11; v++) begin
            do_reset();
            cfg_len_sel = 2'(vt[v].sel);
            cfg_min_gap = GW'(vt[v].mgap);
            L = 216 << vt[v].sel;
            idle(3);
            send_burst(vt[v].n1);
            model_burst(vt[v].n1, 0, 1'b1, L);
            nlast = vt[v].n1;
            if (vt[v].n2 > 0) begin
                idle(vt[v].gap);
                send_burst(vt[v].n2);
                model_burst(vt[v].n2, vt[v].gap, 1'b0, L);
                nlast = vt[v].n2;
            end
            idle(8);
            check($sformatf("v%0d pkt_cnt", v), int'(pkt_cnt), vt[v].e_pkt);
            check($sformatf("v%0d len_err_cnt", v), int'(len_err_cnt), vt[v].e_len);
            check($sformatf("v%0d gap_err_cnt", v), int'(gap_err_cnt), vt[v].e_gap);
            check($sformatf("v%0d out words", v), got_q.size(), vt[v].e_words);
            check($sformatf("v%0d first word latency", v), first_out_cyc - first_in_cyc, 2);
            check($sformatf("v%0d busy in gap", v), int'(busy), 1);
            if (nlast <= L)
                check($sformatf("v%0d eop after valid fall", v), eop_cyc - fall_cyc, 1);
            check_words($sformatf("v%0d", v));
        end

        // Length select changes mid-packet must not affect the packet in flight.
        do_reset();
        cfg_len_sel = 2'b00; cfg_min_gap = 8'd4;
        idle(3);
        send_burst(10);
        cfg_len_sel = 2'b11;
        send_burst(206);
        model_burst(216, 0, 1'b1, 216);
        idle(8);
        check("midsel pkt_cnt", int'(pkt_cnt), 1);
        check_words("midsel");

        // Enable dropped while word 100 of a 1728-word packet is held.
        do_reset();
        cfg_len_sel = 2'b11; cfg_min_gap = 8'd8;
        idle(3);
        send_burst(101);
        tick();
        cfg_en = 1'b0;
        drive_word();
        void'(bq.pop_back());
        void'(bq.pop_back());
        dc = dc - 2'd2;
        model_burst(100, 0, 1'b1, 1728);
        idle(1);
        check("cfg_en drop busy", int'(busy), 0);
        cfg_len_sel = 2'b00;
        tick();
        cfg_en = 1'b1;
        drive_word();
        send_burst(215);
        model_burst(216, 1, 1'b1, 216);
        idle(8);
        check("cfg_en drop pkt_cnt", int'(pkt_cnt), 1);
        check("cfg_en drop len_err_cnt", int'(len_err_cnt), 1);
        check("cfg_en drop gap_err_cnt", int'(gap_err_cnt), 0);
        check_words("cfg_en drop");

        // Reset in the middle of a packet: outputs clear and nothing more appears.
        do_reset();
        cfg_len_sel = 2'b00; cfg_min_gap = '0;
        idle(3);
        send_burst(50);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("midrst flags", int'({bus.out_valid, bus.out_sop, bus.out_eop, bus.out_err, busy}), 0);
        check("midrst counters", int'({pkt_cnt, len_err_cnt, gap_err_cnt}), 0);
        held = got_q.size();
        repeat (2) tick();
        rst = 1'b0;
        idle(10);
        check("midrst no further output", got_q.size(), held);

        // Counter saturation with more short packets than the counter holds.
        do_reset();
        cfg_len_sel = 2'b00; cfg_min_gap = '0;
        idle(3);
        for (int b = 0; b < 9; b++) begin
            send_burst(5);
            model_burst(5, 2, b == 0, 216);
            idle(2);
        end
        idle(6);
        check("saturation len_err_cnt", int'(len_err_cnt), CMAX);
        check_model_counts("saturation");
        check_words("saturation");

`ifdef PKT_RX_SELFTEST_EN
        // Stream jumps ahead at word 50: one mismatch, then resynced.
        do_reset();
        cfg_len_sel = 2'b00; cfg_min_gap = '0;
        idle(3);
        for (int i = 0; i < 216; i++) begin
            tick();
            if (i == 49) dc = 18'd1000;
            drive_word();
        end
        model_burst(216, 0, 1'b1, 216);
        exp_q[49].err = 1'b1;
        idle(8);
        check("selftest data_err_cnt", int'(data_err_cnt), 1);
        check("selftest pkt_cnt", int'(pkt_cnt), 1);
        check_words("selftest");
`endif

        // Random bursts against the packet-level model.
        do_reset();
        cfg_min_gap = GW'($urandom_range(0, 10));
        idle(3);
        begin
            int g_prev, g, n, sel;
            g_prev = 0;
            for (int b = 0; b < 14; b++) begin
                sel = $urandom_range(0, 3);
                cfg_len_sel = 2'(sel);
                L = 216 << sel;
                case ($urandom_range(0, 3))
                    0: n = L;
                    1: n = L + $urandom_range(1, 4);
                    2: n = $urandom_range(2, L - 1);
                    default: n = L - 1;
                endcase
                send_burst(n);
                model_burst(n, g_prev, b == 0, L);
                g = $urandom_range(1, 14);
                idle(g);
                g_prev = g;
            end
        end
        idle(6);
        check_model_counts("random");
        check_words("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_rx_capture.md
Name: pkt_rx_capture

Overview:
- Capture-board receiver for the ASIC package readout stream (ADC_DATA_1..18 + ADC_DATA_VALID, sampled on CLK_RD).
- Frames packets from VALID-high runs, checks length against the configured package type, and checks the inter-packet idle gap.
- Re-emits words as an SOP/EOP-tagged stream with an error flag, plus status counters.
- Sits behind the pad input flops, in the CLK_RD domain; the TB/FPGA consumer takes the output stream.

Parameters:
- DATA_W, 18, pad data width.
- CNT_W, 16, width of the status counters (saturating).
- GAP_W, 8, width of the minimum-gap config.

Ports:
- clk  in  1  CLK_RD-domain clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_en  in  1  receiver enable.
- cfg_len_sel  in  2  package type: 00=216, 01=432, 10=864, 11=1728 words.
- cfg_min_gap  in  GAP_W  minimum VALID-low cycles between packets.
- in_data  in  DATA_W  pad data.
- in_valid  in  1  pad data valid.
- out_data  out  DATA_W  received word.
- out_valid  out  1  word strobe; no backpressure.
- out_sop  out  1  first word of packet.
- out_eop  out  1  last word of packet.
- out_err  out  1  error attached to this word.
- pkt_cnt  out  CNT_W  good packets.
- len_err_cnt  out  CNT_W  short or long packets.
- gap_err_cnt  out  CNT_W  gap violations.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all counters 0.
- Pipeline:
  - Stage 1 registers in_data/in_valid.
  - Stage 2 holds one word until the next sample arrives, so EOP can be tagged by look-ahead.
  - Pad-to-output latency is 2 cycles for every word except the last of a packet.
  - The last word emits 1 cycle after in_valid falls, or on word L.
- L = 216 << cfg_len_sel. Sample cfg_len_sel at SOP; changes mid-packet are ignored.
- Word counter is 11 bits.
- FSM IDLE:
  - Stays in IDLE while cfg_en=0.
  - Registered valid=1 with cfg_en=1 -> RECV. First word gets SOP.
  - At SOP, if gap counter < cfg_min_gap and at least one packet has been seen since reset: increment gap_err_cnt, and that packet's EOP word gets out_err=1.
  - First packet after reset or after a re-enable is exempt from the gap check.
- FSM RECV:
  - Count words.
  - Valid falls at word k<L: held word emitted with EOP, out_err=1, len_err_cnt++ -> GAP.
  - Word L received: emitted with EOP.
    - If valid is still high on the next sample -> DRAIN. Word L already carries EOP, so out_err is not set; len_err_cnt++.
    - Otherwise -> GAP, and pkt_cnt++ if no error.
- FSM DRAIN:
  - Discard words, out_valid=0, until valid is low -> GAP.
- FSM GAP:
  - Gap counter saturates at 2^GAP_W-1, counts valid-low cycles, and is cleared at SOP.
  - Valid high -> RECV with SOP, applying the IDLE gap check.
- L=1 is impossible; SOP and EOP never coincide.
- cfg_en falling mid-packet:
  - Held word emitted with EOP, out_err=1, len_err_cnt++.
  - FSM -> IDLE; gap history is cleared.
- Counters saturate at all-ones. No wrap.
- out_err counts once per packet in len_err_cnt even if the packet has both a length and a gap error. gap_err_cnt is counted independently.
- rst mid-packet: immediate return to reset state. A partial packet produces no further output.

Optional Feature:
- Macro: PKT_RX_SELFTEST_EN.
- Defined:
  - Expected pattern is an 18-bit running counter.
  - The counter starts at 0 after reset, increments per received word (including drained words), and wraps at 2^18.
  - A mismatch sets out_err on that word and increments output data_err_cnt (CNT_W, saturating).
  - After a mismatch the expected value resyncs to received+1.
- Undefined:
  - No checker logic.
  - data_err_cnt port is absent.

Decomposition:
- pkt_rx_pkg holds:
  - len_sel enum with PKT_LEN_216/432/864/1728 constants.
  - Function len_sel -> word count.
  - FSM state enum IDLE/RECV/DRAIN/GAP.
  - Default widths.
- One sub-module, pkt_rx_selftest_chk: pattern compare, resync, and data_err_cnt. Instantiated only under the macro.

Test Plan:
- len_sel=01, min_gap=8, two 432-word VALID bursts separated by 15 low cycles -> 2 SOP/EOP pairs, 432 out_valid each, pkt_cnt=2, error counters 0, first word out 2 cycles after pad.
- len_sel=00, burst of 200 words -> EOP on word 200 with out_err=1, len_err_cnt=1, pkt_cnt=0.
- len_sel=00, burst of 220 words -> EOP on word 216 with out_err=0, words 217-220 dropped, len_err_cnt=1, FSM returns to GAP.
- min_gap=8, two good 216-word packets with 3 idle cycles between -> gap_err_cnt=1, second packet's EOP out_err=1, pkt_cnt=1.
- cfg_en dropped at word 100 of a 1728 packet -> word 100 with EOP and err; next packet after re-enable with 1-cycle gap -> no gap error.
- With PKT_RX_SELFTEST_EN, counter pattern with word 50 corrupted -> data_err_cnt=1, out_err on word 50 only, no further mismatches.
